// File: rtl/nvdla_dbb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nvdla_dbb_pkg
//  Description : Shared widths, W-routing entry type and ID-prefix helper for
//                the NVDLA DBB N-to-1 multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package nvdla_dbb_pkg;

  localparam int DBB_ID_WIDTH  = 8;
  localparam int DBB_LEN_WIDTH = 4;

  // One AW-order FIFO entry: which master owns the burst and its length
  typedef struct packed {
    logic [3:0] idx;
    logic [3:0] len;
  } w_route_t;

  // Number of upper ID bits used to carry the master index
  function automatic int prefix_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nvdla_dbb_intf.sv
`default_nettype none
// ============================================================================
//  Module      : nvdla_dbb_intf
//  Description : AXI-like DBB bundle (AR/AW/W/B/R) with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nvdla_dbb_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  import nvdla_dbb_pkg::*;

  logic                       ar_valid;
  logic                       ar_ready;
  logic [ADDR_WIDTH-1:0]      ar_addr;
  logic [DBB_ID_WIDTH-1:0]    ar_id;
  logic [DBB_LEN_WIDTH-1:0]   ar_len;

  logic                       aw_valid;
  logic                       aw_ready;
  logic [ADDR_WIDTH-1:0]      aw_addr;
  logic [DBB_ID_WIDTH-1:0]    aw_id;
  logic [DBB_LEN_WIDTH-1:0]   aw_len;

  logic                       w_valid;
  logic                       w_ready;
  logic [DATA_WIDTH-1:0]      w_data;
  logic [DATA_WIDTH/8-1:0]    w_strb;
  logic                       w_last;

  logic                       b_valid;
  logic                       b_ready;
  logic [DBB_ID_WIDTH-1:0]    b_id;

  logic                       r_valid;
  logic                       r_ready;
  logic [DBB_ID_WIDTH-1:0]    r_id;
  logic [DATA_WIDTH-1:0]      r_data;
  logic                       r_last;

  modport master (
    output ar_valid, ar_addr, ar_id, ar_len, input ar_ready,
    output aw_valid, aw_addr, aw_id, aw_len, input aw_ready,
    output w_valid, w_data, w_strb, w_last,  input w_ready,
    input  b_valid, b_id,                    output b_ready,
    input  r_valid, r_id, r_data, r_last,    output r_ready
  );

  modport slave (
    input  ar_valid, ar_addr, ar_id, ar_len, output ar_ready,
    input  aw_valid, aw_addr, aw_id, aw_len, output aw_ready,
    input  w_valid, w_data, w_strb, w_last,  output w_ready,
    output b_valid, b_id,                    input b_ready,
    output r_valid, r_id, r_data, r_last,    input r_ready
  );

endinterface
`default_nettype wire

// File: rtl/nvdla_dbb_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : nvdla_dbb_rr_arb
//  Description : Round-robin arbiter with grant lock for AXI-style channels.
//                The grant is frozen while the winner is stalled downstream
//                and the pointer moves past the winner on each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module nvdla_dbb_rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          hold,
  input  logic          hs,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0]  ptr;
  logic [IW-1:0]  lock_idx;
  logic           locked;
  logic [2*N-1:0] req_rot;
  logic [IW-1:0]  pick_idx;
  logic           pick_valid;

  // Rotate so that bit 0 corresponds to the current priority pointer
  assign req_rot = {req, req} >> ptr;

  // First requester at or after the pointer wins
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'((int'(ptr) + i) % N);
      end
    end
  end

  assign grant_idx   = locked ? lock_idx : pick_idx;
  assign grant_valid = locked ? req[lock_idx] : pick_valid;
  assign grant_oh    = grant_valid ? (N'(1) << grant_idx) : '0;

  // Pointer advance on handshake; lock the winner while it is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      lock_idx <= '0;
      locked   <= 1'b0;
    end else if (hs) begin
      ptr    <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
      locked <= 1'b0;
    end else if (hold) begin
      locked   <= 1'b1;
      lock_idx <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nvdla_dbb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : nvdla_dbb_mux
//  Description : N-to-1 DBB multiplexer. Round-robin AR/AW arbitration with
//                the master index carried in the upper ID bits, AW-ordered
//                W steering with regenerated w_last, ID-routed B/R returns.
//  Revision    : 1.0 - initial release
// ============================================================================
module nvdla_dbb_mux
  import nvdla_dbb_pkg::*;
#(
  parameter int N_MASTERS    = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int W_FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  nvdla_dbb_intf.slave  in_dbb [N_MASTERS],
  nvdla_dbb_intf.master out_dbb,
  output logic          w_last_err
);

  localparam int PW = prefix_width(N_MASTERS);
  localparam int LW = DBB_ID_WIDTH - PW;
  localparam int FW = $clog2(W_FIFO_DEPTH);
  localparam int CW = FW + 1;

  // Flattened upstream request signals
  logic [N_MASTERS-1:0]    ar_valid_v, aw_valid_v, w_valid_v, w_last_v;
  logic [N_MASTERS-1:0]    b_ready_v, r_ready_v;
  logic [ADDR_WIDTH-1:0]   ar_addr_a [N_MASTERS];
  logic [ADDR_WIDTH-1:0]   aw_addr_a [N_MASTERS];
  logic [DBB_ID_WIDTH-1:0] ar_id_a   [N_MASTERS];
  logic [DBB_ID_WIDTH-1:0] aw_id_a   [N_MASTERS];
  logic [3:0]              ar_len_a  [N_MASTERS];
  logic [3:0]              aw_len_a  [N_MASTERS];
  logic [DATA_WIDTH-1:0]   w_data_a  [N_MASTERS];
  logic [DATA_WIDTH/8-1:0] w_strb_a  [N_MASTERS];

  // Arbitration
  logic [N_MASTERS-1:0] ar_goh, aw_goh;
  logic [PW-1:0]        ar_gidx, aw_gidx;
  logic                 ar_gvalid, aw_gvalid;
  logic                 ar_hs, aw_hs;

  // Selected request payloads
  logic [ADDR_WIDTH-1:0]   ar_addr_sel, aw_addr_sel;
  logic [LW-1:0]           ar_id_sel, aw_id_sel;
  logic [3:0]              ar_len_sel, aw_len_sel;
  logic                    w_valid_sel, w_last_in;
  logic [DATA_WIDTH-1:0]   w_data_sel;
  logic [DATA_WIDTH/8-1:0] w_strb_sel;

  // AW-order FIFO and W beat tracking
  w_route_t      fifo_mem [W_FIFO_DEPTH];
  w_route_t      head;
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty, push, pop;
  logic [3:0]    beat_cnt;
  logic          w_active, w_last_int, w_hs;

  // Response routing
  logic [PW-1:0] b_sel, r_sel;
  logic          b_rdy_sel, r_rdy_sel;

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_port
    assign ar_valid_v[k] = in_dbb[k].ar_valid;
    assign ar_addr_a[k]  = in_dbb[k].ar_addr;
    assign ar_id_a[k]    = in_dbb[k].ar_id;
    assign ar_len_a[k]   = in_dbb[k].ar_len;
    assign aw_valid_v[k] = in_dbb[k].aw_valid;
    assign aw_addr_a[k]  = in_dbb[k].aw_addr;
    assign aw_id_a[k]    = in_dbb[k].aw_id;
    assign aw_len_a[k]   = in_dbb[k].aw_len;
    assign w_valid_v[k]  = in_dbb[k].w_valid;
    assign w_data_a[k]   = in_dbb[k].w_data;
    assign w_strb_a[k]   = in_dbb[k].w_strb;
    assign w_last_v[k]   = in_dbb[k].w_last;
    assign b_ready_v[k]  = in_dbb[k].b_ready;
    assign r_ready_v[k]  = in_dbb[k].r_ready;

    assign in_dbb[k].ar_ready = ~rst & ar_goh[k] & out_dbb.ar_ready;
    assign in_dbb[k].aw_ready = ~rst & ~fifo_full & aw_goh[k] & out_dbb.aw_ready;
    assign in_dbb[k].w_ready  = w_active & (head.idx == 4'(k)) & out_dbb.w_ready;

    assign in_dbb[k].b_valid  = ~rst & out_dbb.b_valid & (b_sel == PW'(k));
    assign in_dbb[k].b_id     = {{PW{1'b0}}, out_dbb.b_id[LW-1:0]};
    assign in_dbb[k].r_valid  = ~rst & out_dbb.r_valid & (r_sel == PW'(k));
    assign in_dbb[k].r_id     = {{PW{1'b0}}, out_dbb.r_id[LW-1:0]};
    assign in_dbb[k].r_data   = out_dbb.r_data;
    assign in_dbb[k].r_last   = out_dbb.r_last;

    // Upper ID bits are reserved for the master prefix and must arrive as zero
    a_ar_id_prefix : assert property (@(posedge clk) disable iff (rst)
      ar_valid_v[k] |-> (ar_id_a[k][DBB_ID_WIDTH-1:LW] == '0));
    a_aw_id_prefix : assert property (@(posedge clk) disable iff (rst)
      aw_valid_v[k] |-> (aw_id_a[k][DBB_ID_WIDTH-1:LW] == '0));
  end

  nvdla_dbb_rr_arb #(.N(N_MASTERS), .IW(PW)) u_ar_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (ar_valid_v),
    .hold        (out_dbb.ar_valid & ~out_dbb.ar_ready),
    .hs          (ar_hs),
    .grant_oh    (ar_goh),
    .grant_idx   (ar_gidx),
    .grant_valid (ar_gvalid)
  );

  nvdla_dbb_rr_arb #(.N(N_MASTERS), .IW(PW)) u_aw_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (aw_valid_v),
    .hold        (out_dbb.aw_valid & ~out_dbb.aw_ready),
    .hs          (aw_hs),
    .grant_oh    (aw_goh),
    .grant_idx   (aw_gidx),
    .grant_valid (aw_gvalid)
  );

  // Steer the granted AR/AW request and the FIFO-head W beat downstream
  always_comb begin
    ar_addr_sel = '0;
    ar_id_sel   = '0;
    ar_len_sel  = '0;
    aw_addr_sel = '0;
    aw_id_sel   = '0;
    aw_len_sel  = '0;
    w_valid_sel = 1'b0;
    w_last_in   = 1'b0;
    w_data_sel  = '0;
    w_strb_sel  = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (ar_gidx == PW'(k)) begin
        ar_addr_sel = ar_addr_a[k];
        ar_id_sel   = ar_id_a[k][LW-1:0];
        ar_len_sel  = ar_len_a[k];
      end
      if (aw_gidx == PW'(k)) begin
        aw_addr_sel = aw_addr_a[k];
        aw_id_sel   = aw_id_a[k][LW-1:0];
        aw_len_sel  = aw_len_a[k];
      end
      if (head.idx == 4'(k)) begin
        w_valid_sel = w_valid_v[k];
        w_last_in   = w_last_v[k];
        w_data_sel  = w_data_a[k];
        w_strb_sel  = w_strb_a[k];
      end
    end
  end

  assign out_dbb.ar_valid = ~rst & ar_gvalid;
  assign out_dbb.ar_addr  = ar_addr_sel;
  assign out_dbb.ar_id    = {ar_gidx, ar_id_sel};
  assign out_dbb.ar_len   = ar_len_sel;
  assign ar_hs            = out_dbb.ar_valid & out_dbb.ar_ready;

  assign out_dbb.aw_valid = ~rst & aw_gvalid & ~fifo_full;
  assign out_dbb.aw_addr  = aw_addr_sel;
  assign out_dbb.aw_id    = {aw_gidx, aw_id_sel};
  assign out_dbb.aw_len   = aw_len_sel;
  assign aw_hs            = out_dbb.aw_valid & out_dbb.aw_ready;

  assign fifo_full  = (count == CW'(W_FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];
  assign push       = aw_hs;
  assign pop        = w_hs & w_last_int;

  // Registered FIFO storage: no bypass, so a new entry is visible next cycle
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{idx: 4'(aw_gidx), len: aw_len_sel};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign w_active         = ~rst & ~fifo_empty;
  assign w_last_int       = (beat_cnt == head.len);
  assign out_dbb.w_valid  = w_active & w_valid_sel;
  assign out_dbb.w_data   = w_data_sel;
  assign out_dbb.w_strb   = w_strb_sel;
  assign out_dbb.w_last   = w_last_int;
  assign w_hs             = out_dbb.w_valid & out_dbb.w_ready;
  assign w_last_err       = w_hs & (w_last_in != w_last_int);

  // Beat counter within the burst at the FIFO head
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (w_hs) begin
      beat_cnt <= w_last_int ? '0 : beat_cnt + 1'b1;
    end
  end

  assign b_sel = out_dbb.b_id[DBB_ID_WIDTH-1:LW];
  assign r_sel = out_dbb.r_id[DBB_ID_WIDTH-1:LW];

  // Pick the owning master's ready; unmapped prefixes are sunk
  always_comb begin
    b_rdy_sel = 1'b1;
    r_rdy_sel = 1'b1;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (b_sel == PW'(k)) b_rdy_sel = b_ready_v[k];
      if (r_sel == PW'(k)) r_rdy_sel = r_ready_v[k];
    end
  end

  assign out_dbb.b_ready = ~rst & b_rdy_sel;
  assign out_dbb.r_ready = ~rst & r_rdy_sel;

endmodule
`default_nettype wire

// File: tb/tb_nvdla_dbb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nvdla_dbb_mux
//  Description : Directed self-checking bench for nvdla_dbb_mux, 4 masters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nvdla_dbb_mux;

  localparam int NM = 4;

  logic clk = 1'b0;
  logic rst;
  logic w_last_err;
  int   n_cmp = 0;
  int   n_err = 0;

  nvdla_dbb_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) up [NM] ();
  nvdla_dbb_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dn ();

  // Upstream master-side stimulus and observation
  logic [NM-1:0] m_ar_valid, m_aw_valid, m_w_valid, m_w_last, m_b_ready, m_r_ready;
  logic [31:0]   m_ar_addr [NM];
  logic [31:0]   m_aw_addr [NM];
  logic [7:0]    m_ar_id   [NM];
  logic [7:0]    m_aw_id   [NM];
  logic [3:0]    m_ar_len  [NM];
  logic [3:0]    m_aw_len  [NM];
  logic [63:0]   m_w_data  [NM];
  logic [7:0]    m_w_strb  [NM];
  logic [NM-1:0] o_ar_ready, o_aw_ready, o_w_ready, o_b_valid, o_r_valid, o_r_last;
  logic [7:0]    o_b_id    [NM];
  logic [7:0]    o_r_id    [NM];
  logic [63:0]   o_r_data  [NM];

  for (genvar k = 0; k < NM; k++) begin : g_up
    assign up[k].ar_valid = m_ar_valid[k];
    assign up[k].ar_addr  = m_ar_addr[k];
    assign up[k].ar_id    = m_ar_id[k];
    assign up[k].ar_len   = m_ar_len[k];
    assign up[k].aw_valid = m_aw_valid[k];
    assign up[k].aw_addr  = m_aw_addr[k];
    assign up[k].aw_id    = m_aw_id[k];
    assign up[k].aw_len   = m_aw_len[k];
    assign up[k].w_valid  = m_w_valid[k];
    assign up[k].w_data   = m_w_data[k];
    assign up[k].w_strb   = m_w_strb[k];
    assign up[k].w_last   = m_w_last[k];
    assign up[k].b_ready  = m_b_ready[k];
    assign up[k].r_ready  = m_r_ready[k];
    assign o_ar_ready[k]  = up[k].ar_ready;
    assign o_aw_ready[k]  = up[k].aw_ready;
    assign o_w_ready[k]   = up[k].w_ready;
    assign o_b_valid[k]   = up[k].b_valid;
    assign o_b_id[k]      = up[k].b_id;
    assign o_r_valid[k]   = up[k].r_valid;
    assign o_r_id[k]      = up[k].r_id;
    assign o_r_data[k]    = up[k].r_data;
    assign o_r_last[k]    = up[k].r_last;
  end

  nvdla_dbb_mux #(
    .N_MASTERS    (NM),
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (64),
    .W_FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_dbb     (up),
    .out_dbb    (dn),
    .w_last_err (w_last_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- idle / reset ----------------
    rst = 1'b1;
    m_ar_valid = '0; m_aw_valid = '0; m_w_valid = '0; m_w_last = '0;
    m_b_ready = '0; m_r_ready = '0;
    for (int k = 0; k < NM; k++) begin
      m_ar_addr[k] = 32'h1000 * (k + 1);
      m_ar_id[k]   = 8'h10 + 8'(k);
      m_ar_len[k]  = 4'(k);
      m_aw_addr[k] = 32'h8000 + 32'h100 * k;
      m_aw_id[k]   = 8'h00;
      m_aw_len[k]  = 4'd0;
      m_w_data[k]  = 64'h1111_1111_1111_1111 * (k + 1);
      m_w_strb[k]  = 8'hF0 | 8'(k);
    end
    dn.ar_ready = 1'b1; dn.aw_ready = 1'b1; dn.w_ready = 1'b1;
    dn.b_valid = 1'b0; dn.b_id = '0;
    dn.r_valid = 1'b0; dn.r_id = '0; dn.r_data = '0; dn.r_last = 1'b0;
    tick();
    m_ar_valid = 4'b0001; m_aw_valid = 4'b0001;
    settle();
    chk("rst_ar_valid", 64'(dn.ar_valid), 64'd0);
    chk("rst_aw_valid", 64'(dn.aw_valid), 64'd0);
    chk("rst_ar_ready", 64'(o_ar_ready), 64'd0);
    chk("rst_w_valid",  64'(dn.w_valid), 64'd0);
    tick();
    rst = 1'b0; m_ar_valid = '0; m_aw_valid = '0;
    settle();
    chk("idle_ar_valid", 64'(dn.ar_valid), 64'd0);
    chk("idle_w_err",    64'(w_last_err), 64'd0);
    tick();

    // ---------------- AR round-robin fairness ----------------
    m_ar_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("ar_rr_addr",  64'(dn.ar_addr), 64'(32'h1000 * ((c % 4) + 1)));
      chk("ar_rr_id",    64'(dn.ar_id),   64'(((c % 4) << 6) | (16 + (c % 4))));
      chk("ar_rr_ready", 64'(o_ar_ready), 64'(1 << (c % 4)));
      tick();
    end
    m_ar_valid = '0;

    // ---------------- AR lock ----------------
    dn.ar_ready = 1'b0;
    m_ar_valid = 4'b0010;
    settle();
    chk("lock_addr0", 64'(dn.ar_addr), 64'h2000);
    tick();
    m_ar_valid = 4'b0011;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("lock_id",    64'(dn.ar_id),    64'h51);
      chk("lock_addr",  64'(dn.ar_addr),  64'h2000);
      chk("lock_ready", 64'(o_ar_ready),  64'd0);
      tick();
    end
    dn.ar_ready = 1'b1;
    settle();
    chk("lock_hs_id",    64'(dn.ar_id),   64'h51);
    chk("lock_hs_ready", 64'(o_ar_ready), 64'b0010);
    tick();
    m_ar_valid = 4'b0001;
    settle();
    chk("lock_next_addr",  64'(dn.ar_addr), 64'h1000);
    chk("lock_next_ready", 64'(o_ar_ready), 64'b0001);
    tick();
    m_ar_valid = '0;

    // ---------------- W ordering ----------------
    m_aw_id[2] = 8'h01; m_aw_len[2] = 4'd3;
    m_aw_id[0] = 8'h07; m_aw_len[0] = 4'd0;
    m_aw_valid = 4'b0100;
    m_w_valid  = 4'b0101;
    settle();
    chk("aw_m2_id",     64'(dn.aw_id),     64'h81);
    chk("aw_m2_len",    64'(dn.aw_len),    64'd3);
    chk("w_no_bypass",  64'(dn.w_valid),   64'd0);
    chk("w_rdy_empty",  64'(o_w_ready),    64'd0);
    tick();
    m_aw_valid = 4'b0001;
    settle();
    chk("aw_m0_id",     64'(dn.aw_id),     64'h07);
    chk("w_b1_valid",   64'(dn.w_valid),   64'd1);
    chk("w_b1_data",    dn.w_data,         64'h3333_3333_3333_3333);
    chk("w_b1_strb",    64'(dn.w_strb),    64'hF2);
    chk("w_b1_last",    64'(dn.w_last),    64'd0);
    chk("w_b1_ready",   64'(o_w_ready),    64'b0100);
    tick();
    m_aw_valid = '0;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("w_mid_data",  dn.w_data,        64'h3333_3333_3333_3333);
      chk("w_mid_last",  64'(dn.w_last),   64'd0);
      chk("w_mid_ready", 64'(o_w_ready),   64'b0100);
      tick();
    end
    m_w_last[2] = 1'b1;
    settle();
    chk("w_b4_last",    64'(dn.w_last),    64'd1);
    chk("w_b4_data",    dn.w_data,         64'h3333_3333_3333_3333);
    chk("w_b4_err",     64'(w_last_err),   64'd0);
    tick();
    m_w_last = 4'b0001; m_w_valid = 4'b0001;
    settle();
    chk("w_m0_valid",   64'(dn.w_valid),   64'd1);
    chk("w_m0_data",    dn.w_data,         64'h1111_1111_1111_1111);
    chk("w_m0_last",    64'(dn.w_last),    64'd1);
    chk("w_m0_ready",   64'(o_w_ready),    64'b0001);
    tick();
    settle();
    chk("w_drained",    64'(dn.w_valid),   64'd0);
    tick();
    m_w_valid = '0; m_w_last = '0;

    // ---------------- FIFO full ----------------
    m_aw_len[1] = 4'd1;
    m_aw_valid  = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("full_fill_rdy", 64'(o_aw_ready), 64'b0010);
      tick();
    end
    settle();
    chk("full_blk_rdy",  64'(o_aw_ready), 64'd0);
    chk("full_blk_vld",  64'(dn.aw_valid), 64'd0);
    tick();
    m_w_valid = 4'b0010;
    settle();
    chk("full_w_valid",  64'(dn.w_valid), 64'd1);
    chk("full_b0_rdy",   64'(o_aw_ready), 64'd0);
    tick();
    m_w_last = 4'b0010;
    settle();
    chk("full_w_last",   64'(dn.w_last),  64'd1);
    chk("full_pop_rdy",  64'(o_aw_ready), 64'd0);
    tick();
    m_w_valid = '0; m_w_last = '0;
    settle();
    chk("full_after_rdy", 64'(o_aw_ready), 64'b0010);
    tick();
    m_aw_valid = '0;

    // ---------------- reset mid-burst ----------------
    m_w_valid = 4'b0010;
    tick();
    rst = 1'b1; m_aw_valid = 4'b0010;
    settle();
    chk("mrst_w_valid",  64'(dn.w_valid),  64'd0);
    chk("mrst_aw_valid", 64'(dn.aw_valid), 64'd0);
    chk("mrst_aw_rdy",   64'(o_aw_ready),  64'd0);
    tick();
    rst = 1'b0; m_aw_valid = '0;
    settle();
    chk("post_rst_w_valid", 64'(dn.w_valid), 64'd0);
    chk("post_rst_w_rdy",   64'(o_w_ready),  64'd0);
    tick();
    m_w_valid = '0;

    // ---------------- w_last error ----------------
    m_aw_len[3] = 4'd3;
    m_aw_valid = 4'b1000;
    tick();
    m_aw_valid = '0; m_w_valid = 4'b1000;
    settle();
    chk("err_b1", 64'(w_last_err), 64'd0);
    tick();
    m_w_last = 4'b1000;
    settle();
    chk("err_b2", 64'(w_last_err), 64'd1);
    tick();
    m_w_last = '0;
    settle();
    chk("err_b3", 64'(w_last_err), 64'd0);
    tick();
    m_w_last = 4'b1000;
    settle();
    chk("err_b4_last", 64'(dn.w_last),  64'd1);
    chk("err_b4",      64'(w_last_err), 64'd0);
    tick();
    m_w_valid = '0; m_w_last = '0;

    // ---------------- response routing ----------------
    dn.r_valid = 1'b1; dn.r_id = 8'b01_000101; dn.r_data = 64'hDEAD_BEEF_0000_0001; dn.r_last = 1'b1;
    m_r_ready = 4'b0010;
    settle();
    chk("r_valid_vec", 64'(o_r_valid),  64'b0010);
    chk("r_id_up",     64'(o_r_id[1]),  64'h05);
    chk("r_data_up",   o_r_data[1],     64'hDEAD_BEEF_0000_0001);
    chk("r_last_up",   64'(o_r_last[1]), 64'd1);
    chk("r_ready_dn",  64'(dn.r_ready), 64'd1);
    tick();
    m_r_ready = 4'b1101;
    settle();
    chk("r_ready_bp",  64'(dn.r_ready), 64'd0);
    tick();
    dn.r_valid = 1'b0;
    dn.b_valid = 1'b1; dn.b_id = 8'hC3; m_b_ready = 4'b1000;
    settle();
    chk("b_valid_vec", 64'(o_b_valid),  64'b1000);
    chk("b_id_up",     64'(o_b_id[3]),  64'h03);
    chk("b_ready_dn",  64'(dn.b_ready), 64'd1);
    tick();
    dn.b_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
